// File: rtl/rv_reg_file.sv
// rv_reg_file: 32-entry RV32I integer register file.
// Two registered read ports (rs1, rs2), one write port (rd), x0 hardwired to 0.
// Optional build macro REG_FILE_WR_BYPASS_EN selects write-first behaviour on a
// same-cycle read/write collision; when it is undefined the read is read-first.
module rv_reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_re,
  input  logic                  i_wr,
  input  logic [ADDR_WIDTH-1:0] i_rs1,
  input  logic [ADDR_WIDTH-1:0] i_rs2,
  input  logic [ADDR_WIDTH-1:0] i_rd,
  input  logic [DATA_WIDTH-1:0] i_write_data,
  output logic [DATA_WIDTH-1:0] o_read_data1,
  output logic [DATA_WIDTH-1:0] o_read_data2
);

  // Flat view of the architectural state; entry 0 is a constant zero.
  logic [DATA_WIDTH-1:0] reg_view [NUM_REGS];

  logic [DATA_WIDTH-1:0] read_data1_reg, read_data1_next;
  logic [DATA_WIDTH-1:0] read_data2_reg, read_data2_next;

  // A write is only effective when it targets a real (nonzero) register.
  logic wr_active;
  assign wr_active = i_wr && (i_rd != '0);

  // Storage: one register per architectural index; x0 has no storage at all,
  // so writes to it vanish and reads of it are always zero.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_regs
      if (gi == 0) begin : g_x0
        assign reg_view[gi] = '0;
      end else begin : g_xn
        logic [DATA_WIDTH-1:0] value_reg;

        // Clear on reset, otherwise capture write data when this index is addressed.
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            value_reg <= '0;
          end else if (wr_active && (i_rd == ADDR_WIDTH'(gi))) begin
            value_reg <= i_write_data;
          end
        end

        assign reg_view[gi] = value_reg;
      end
    end
  endgenerate

  // Collision detection between each read port and the write port.
  logic bypass1, bypass2;
`ifdef REG_FILE_WR_BYPASS_EN
  assign bypass1 = wr_active && (i_rd == i_rs1);
  assign bypass2 = wr_active && (i_rd == i_rs2);
`else
  assign bypass1 = 1'b0;
  assign bypass2 = 1'b0;
`endif

  // Next read data: hold when not reading, otherwise select stored or forwarded data.
  always_comb begin
    read_data1_next = read_data1_reg;
    read_data2_next = read_data2_reg;
    if (i_re) begin
      read_data1_next = bypass1 ? i_write_data : reg_view[i_rs1];
      read_data2_next = bypass2 ? i_write_data : reg_view[i_rs2];
    end
  end

  // Registered read outputs; reset wins over any read in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      read_data1_reg <= '0;
      read_data2_reg <= '0;
    end else begin
      read_data1_reg <= read_data1_next;
      read_data2_reg <= read_data2_next;
    end
  end

  assign o_read_data1 = read_data1_reg;
  assign o_read_data2 = read_data2_reg;

endmodule

// File: tb/tb_rv_reg_file.sv
// Directed testbench for rv_reg_file with a one-deep expected-result scoreboard.
module tb_rv_reg_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_re;
  logic        i_wr;
  logic [4:0]  i_rs1;
  logic [4:0]  i_rs2;
  logic [4:0]  i_rd;
  logic [31:0] i_write_data;
  logic [31:0] o_read_data1;
  logic [31:0] o_read_data2;

  int compared   = 0;
  int mismatched = 0;

  typedef struct packed {
    logic [31:0] d1;
    logic [31:0] d2;
  } exp_t;

  exp_t sb_q[$];
  string tag_q[$];

  rv_reg_file #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5),
    .NUM_REGS(32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_re         (i_re),
    .i_wr         (i_wr),
    .i_rs1        (i_rs1),
    .i_rs2        (i_rs2),
    .i_rd         (i_rd),
    .i_write_data (i_write_data),
    .o_read_data1 (o_read_data1),
    .o_read_data2 (o_read_data2)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int idx);
    logic [31:0] v;
    v = {8'(idx), 8'hC3, 8'(idx * 7), 8'h5A};
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle; when chk is set, the expected outputs after this edge are
  // queued at drive time and popped/compared once the edge has happened.
  task automatic cycle(input logic rst, input logic re, input logic wr,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [31:0] wd,
                       input bit chk, input logic [31:0] e1, input logic [31:0] e2,
                       input string tag);
    exp_t e;
    string t;
    rst_n        = rst;
    i_re         = re;
    i_wr         = wr;
    i_rs1        = rs1;
    i_rs2        = rs2;
    i_rd         = rd;
    i_write_data = wd;
    if (chk) begin
      e.d1 = e1;
      e.d2 = e2;
      sb_q.push_back(e);
      tag_q.push_back(tag);
    end
    @(posedge clk);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      check({t, "_p1"}, o_read_data1, e.d1);
      check({t, "_p2"}, o_read_data2, e.d2);
      $display("txn %-12s rs1=%0d rs2=%0d d1=%h d2=%h", t, rs1, rs2, o_read_data1, o_read_data2);
    end
  endtask

  initial begin
    logic [31:0] coll_exp;

    // Reset: outputs clear.
    cycle(0, 0, 0, 0, 0, 0, 32'h0, 1, 32'h0, 32'h0, "reset");
    cycle(1, 1, 0, 5, 7, 0, 32'h0, 1, 32'h0, 32'h0, "rd_after_rst");

    // Write then read.
    cycle(1, 0, 1, 0, 0, 5, 32'hABCDEFFF, 0, 32'h0, 32'h0, "wr5");
    cycle(1, 0, 1, 0, 0, 7, 32'hABCDADFF, 0, 32'h0, 32'h0, "wr7");
    cycle(1, 1, 0, 5, 7, 0, 32'h0, 1, 32'hABCDEFFF, 32'hABCDADFF, "rd5_7");

    // Same-cycle read and write of r5.
`ifdef REG_FILE_WR_BYPASS_EN
    coll_exp = 32'h12345678;
`else
    coll_exp = 32'hABCDEFFF;
`endif
    cycle(1, 1, 1, 5, 7, 5, 32'h12345678, 1, coll_exp, 32'hABCDADFF, "collide");
    cycle(1, 1, 0, 5, 7, 0, 32'h0, 1, 32'h12345678, 32'hABCDADFF, "after_coll");

    // x0: writes discarded, reads zero, also on a same-cycle collision.
    cycle(1, 0, 1, 0, 0, 0, 32'hFFFFFFFF, 0, 32'h0, 32'h0, "wr_x0");
    cycle(1, 1, 0, 0, 0, 0, 32'h0, 1, 32'h0, 32'h0, "rd_x0");
    cycle(1, 1, 1, 0, 0, 0, 32'hFFFFFFFF, 1, 32'h0, 32'h0, "coll_x0");

    // Both ports on the same register.
    cycle(1, 1, 0, 5, 5, 0, 32'h0, 1, 32'h12345678, 32'h12345678, "same_reg");

    // Hold: i_re=0 keeps outputs while r5 is overwritten.
    cycle(1, 0, 1, 5, 5, 5, 32'h0, 1, 32'h12345678, 32'h12345678, "hold_wr");
    cycle(1, 0, 0, 7, 7, 0, 32'h0, 1, 32'h12345678, 32'h12345678, "hold_idle");
    cycle(1, 1, 0, 5, 7, 0, 32'h0, 1, 32'h0, 32'hABCDADFF, "rd_new5");

    // Fill every register with a distinct pattern, then read mirrored pairs.
    for (int i = 0; i < 32; i++) begin
      cycle(1, 0, 1, 0, 0, 5'(i), pat(i), 0, 32'h0, 32'h0, "fill");
    end
    for (int i = 0; i < 32; i++) begin
      cycle(1, 1, 0, 5'(i), 5'(31 - i), 0, 32'h0, 1,
            (i == 0) ? 32'h0 : pat(i), (i == 31) ? 32'h0 : pat(31 - i), "sweep");
    end

    // Mid-operation reset overrides a write and a read in the same cycle.
    cycle(0, 1, 1, 7, 31, 7, 32'h55555555, 1, 32'h0, 32'h0, "midop_rst");
    cycle(1, 1, 0, 7, 31, 0, 32'h0, 1, 32'h0, 32'h0, "rd_after_mid");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
